// File: rtl/computer_cpu.sv
// Single-cycle 8-bit accumulator processor: PC, 256x15 instruction ROM, registers A/B,
// operand muxes and an 8-bit ALU. Every instruction retires on the rising clock edge.
module computer_cpu #(
  parameter string ROM_FILE = ""
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] alu_out_bus,
  output logic [7:0] regA_out_bus,
  output logic [7:0] regB_out_bus
);

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {SA_A, SA_B, SA_ZERO} sel_a_t;
  typedef enum logic [1:0] {SB_B, SB_LIT, SB_ZERO} sel_b_t;
  typedef enum logic [2:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHL, OP_SHR
  } alu_op_t;

  logic [14:0]       rom [256];
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;

  logic [6:0]        opcode;
  logic [DATA_W-1:0] lit;
  sel_a_t            sel_a;
  sel_b_t            sel_b;
  alu_op_t           alu_op;
  logic              wr_a;
  logic              wr_b;
  logic              jmp;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic [DATA_W-1:0] alu_res;

  // ROM image is fixed at elaboration; empty file name selects the count program.
  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 15'h0000;
    if (ROM_FILE == "") begin
      rom[0] = 15'h0300;  // MOV A,0
      rom[1] = 15'h0401;  // MOV B,1
      rom[2] = 15'h0500;  // ADD A,B
      rom[3] = 15'h1102;  // JMP 2
    end
  end

  assign opcode = rom[pc][14:8];
  assign lit    = rom[pc][7:0];

  function automatic logic [DATA_W-1:0] alu(input alu_op_t op,
                                            input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOT:  return ~a;
      OP_SHL:  return {a[DATA_W-2:0], 1'b0};
      OP_SHR:  return {1'b0, a[DATA_W-1:1]};
      default: return '0;
    endcase
  endfunction

  // Decode: MOVs are 0+operand so the moved value appears on the ALU bus.
  always_comb begin
    sel_a  = SA_ZERO;
    sel_b  = SB_ZERO;
    alu_op = OP_ADD;
    wr_a   = 1'b0;
    wr_b   = 1'b0;
    jmp    = 1'b0;
    case (opcode)
      7'h01: begin sel_b = SB_B;                         wr_a = 1'b1; end
      7'h02: begin sel_a = SA_A;                         wr_b = 1'b1; end
      7'h03: begin sel_b = SB_LIT;                       wr_a = 1'b1; end
      7'h04: begin sel_b = SB_LIT;                       wr_b = 1'b1; end
      7'h05: begin sel_a = SA_A; sel_b = SB_B;           wr_a = 1'b1; end
      7'h06: begin sel_a = SA_A; sel_b = SB_B;           wr_b = 1'b1; end
      7'h07: begin sel_a = SA_A; sel_b = SB_LIT;         wr_a = 1'b1; end
      7'h08: begin sel_a = SA_A; sel_b = SB_B;   alu_op = OP_SUB; wr_a = 1'b1; end
      7'h09: begin sel_a = SA_A; sel_b = SB_B;   alu_op = OP_SUB; wr_b = 1'b1; end
      7'h0A: begin sel_a = SA_A; sel_b = SB_LIT; alu_op = OP_SUB; wr_a = 1'b1; end
      7'h0B: begin sel_a = SA_A; sel_b = SB_B;   alu_op = OP_AND; wr_a = 1'b1; end
      7'h0C: begin sel_a = SA_A; sel_b = SB_B;   alu_op = OP_OR;  wr_a = 1'b1; end
      7'h0D: begin sel_a = SA_A; sel_b = SB_B;   alu_op = OP_XOR; wr_a = 1'b1; end
      7'h0E: begin sel_a = SA_A;                 alu_op = OP_NOT; wr_a = 1'b1; end
      7'h0F: begin sel_a = SA_A;                 alu_op = OP_SHL; wr_a = 1'b1; end
      7'h10: begin sel_a = SA_A;                 alu_op = OP_SHR; wr_a = 1'b1; end
      7'h11: begin jmp = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    case (sel_a)
      SA_A:    opnd_a = reg_a;
      SA_B:    opnd_a = reg_b;
      default: opnd_a = '0;
    endcase
    case (sel_b)
      SB_B:    opnd_b = reg_b;
      SB_LIT:  opnd_b = lit;
      default: opnd_b = '0;
    endcase
  end

  assign alu_res = alu(alu_op, opnd_a, opnd_b);

  // Architectural state: retire the current instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= '0;
      reg_a <= '0;
      reg_b <= '0;
    end else begin
      pc <= jmp ? lit : pc + 8'd1;
      if (wr_a) reg_a <= alu_res;
      if (wr_b) reg_b <= alu_res;
    end
  end

  assign alu_out_bus  = alu_res;
  assign regA_out_bus = reg_a;
  assign regB_out_bus = reg_b;

endmodule

// File: tb/tb_computer_cpu.sv
// Directed bench for computer_cpu: reset, count program, wrap-around, ALU ops,
// PC wrap and JMP-to-self, with custom programs loaded into the ROM array by backdoor.
module tb_computer_cpu;

  logic       clk;
  logic       rst_n;
  logic [7:0] alu_out_bus;
  logic [7:0] regA_out_bus;
  logic [7:0] regB_out_bus;

  int n_checks = 0;
  int n_pass   = 0;

  computer_cpu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .alu_out_bus  (alu_out_bus),
    .regA_out_bus (regA_out_bus),
    .regB_out_bus (regB_out_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance n rising edges, then settle away from the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) dut.rom[i] = 15'h0000;
  endtask

  // ALU program: MOV A,F0; MOV B,3C; ADD A,B; SUB B,A; AND A,B; NOT A; SHL A; SHR A
  logic [14:0] alu_prog [8] = '{15'h03F0, 15'h043C, 15'h0500, 15'h0900,
                                15'h0B00, 15'h0E00, 15'h0F00, 15'h1000};
  logic [7:0]  alu_exp  [8] = '{8'hF0, 8'h3C, 8'h2C, 8'hF0, 8'h20, 8'hDF, 8'hBE, 8'h5F};
  bit          alu_to_b [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [7:0]  cnt_exp  [6] = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2};

  initial begin
    rst_n = 1'b0;
    #1;
    check("reset_a", regA_out_bus, 8'h00);
    check("reset_b", regB_out_bus, 8'h00);
    check("reset_alu", alu_out_bus, 8'h00);

    // Run the count program to A=5, then assert reset mid-cycle.
    @(posedge clk); #2;
    rst_n = 1'b1;
    step(11);
    check("pre_reset_a5", regA_out_bus, 8'h05);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_a", regA_out_bus, 8'h00);
    check("async_reset_b", regB_out_bus, 8'h00);
    check("async_reset_pc", dut.pc, 8'h00);
    check("async_reset_alu", alu_out_bus, 8'h00);
    #1 rst_n = 1'b1;
    #1;
    check("release_no_change_a", regA_out_bus, 8'h00);

    // Count program from a fresh release.
    for (int n = 1; n <= 6; n++) begin
      step(1);
      check($sformatf("count_a_edge%0d", n), regA_out_bus, cnt_exp[n-1]);
      check($sformatf("count_b_edge%0d", n), regB_out_bus, (n >= 2) ? 8'h01 : 8'h00);
      if (n == 2) check("count_alu_add_edge2", alu_out_bus, 8'h01);
    end
    step(34);
    check("count_a_edge40", regA_out_bus, 8'd19);
    check("count_b_edge40", regB_out_bus, 8'd1);
    step(471);
    check("wrap_a_edge511", regA_out_bus, 8'hFF);
    step(1);
    check("wrap_a_edge512", regA_out_bus, 8'hFF);
    step(1);
    check("wrap_a_edge513", regA_out_bus, 8'h00);
    check("wrap_b_edge513", regB_out_bus, 8'h01);

    // ALU program.
    rst_n = 1'b0;
    clear_rom();
    for (int i = 0; i < 8; i++) dut.rom[i] = alu_prog[i];
    #1;
    check("alu_reset_rom0", alu_out_bus, 8'hF0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("alu_bus_step%0d", k), alu_out_bus, alu_exp[k]);
      step(1);
      if (alu_to_b[k]) check($sformatf("alu_b_step%0d", k), regB_out_bus, alu_exp[k]);
      else             check($sformatf("alu_a_step%0d", k), regA_out_bus, alu_exp[k]);
    end
    check("alu_final_b", regB_out_bus, 8'hF0);

    // PC wrap: only addr 0, 1 and 255 hold non-NOP instructions.
    rst_n = 1'b0;
    clear_rom();
    dut.rom[0]   = 15'h0409;
    dut.rom[1]   = 15'h0400;
    dut.rom[255] = 15'h0307;
    #1 rst_n = 1'b1;
    step(1);
    check("pcwrap_b_edge1", regB_out_bus, 8'h09);
    step(254);
    check("pcwrap_a_edge255", regA_out_bus, 8'h00);
    check("pcwrap_b_edge255", regB_out_bus, 8'h00);
    step(1);
    check("pcwrap_a_edge256", regA_out_bus, 8'h07);
    check("pcwrap_alu_rom0", alu_out_bus, 8'h09);
    step(1);
    check("pcwrap_b_edge257", regB_out_bus, 8'h09);

    // JMP to own address.
    rst_n = 1'b0;
    clear_rom();
    dut.rom[0] = 15'h0311;
    dut.rom[1] = 15'h0422;
    dut.rom[2] = 15'h1102;
    #1 rst_n = 1'b1;
    step(3);
    check("jself_a_setup", regA_out_bus, 8'h11);
    check("jself_b_setup", regB_out_bus, 8'h22);
    for (int k = 0; k < 10; k++) begin
      step(1);
      check($sformatf("jself_a_%0d", k), regA_out_bus, 8'h11);
      check($sformatf("jself_b_%0d", k), regB_out_bus, 8'h22);
      check($sformatf("jself_pc_%0d", k), dut.pc, 8'h02);
      check($sformatf("jself_alu_%0d", k), alu_out_bus, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
